// File: rtl/seq_adder_mc.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per cycle with the carry
// held in a register between steps, then publishes sum and flags.
//
// state | meaning
// IDLE  | waiting for start_i, ready_o=1
// BUSY  | adding chunk k_q, ready_o=0
// DONE  | result just loaded, valid_o=1, may accept a new start
module seq_adder_mc #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             sub_i,
   input  logic [WIDTH-1:0] src1_i,
   input  logic [WIDTH-1:0] src2_i,
   output logic             ready_o,
   output logic             valid_o,
   output logic [WIDTH-1:0] sum_o,
   output logic             cout_o,
   output logic             ovf_o,
   output logic             zero_o
);

   localparam int STEPS = WIDTH / CHUNK;
   localparam int KW    = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(STEPS - 1);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] partial_q;
   logic [WIDTH-1:0] partial_nxt;
   logic             c_q;
   logic [KW-1:0]    k_q;
   logic [CHUNK:0]   step_sum;
   logic             accept;
   logic             last_step;

   assign ready_o   = (state != S_BUSY);
   assign valid_o   = (state == S_DONE);
   assign accept    = start_i && ready_o;
   assign last_step = (state == S_BUSY) && (k_q == K_LAST);

   // State register.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic; a start in DONE chains straight into BUSY.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start_i) state_nxt = S_BUSY;
         S_BUSY:  if (k_q == K_LAST) state_nxt = S_DONE;
         S_DONE:  state_nxt = start_i ? S_BUSY : S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // One chunk of the ripple add, merged into the running partial sum.
   always_comb begin
      step_sum = {1'b0, a_q[k_q*CHUNK +: CHUNK]}
               + {1'b0, b_q[k_q*CHUNK +: CHUNK]}
               + {{CHUNK{1'b0}}, c_q};
      partial_nxt = partial_q;
      partial_nxt[k_q*CHUNK +: CHUNK] = step_sum[CHUNK-1:0];
   end

   // Operand capture and per-step accumulation; subtraction is A + ~B + 1.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         a_q       <= '0;
         b_q       <= '0;
         partial_q <= '0;
         c_q       <= 1'b0;
         k_q       <= '0;
      end else if (accept) begin
         a_q       <= src1_i;
         b_q       <= sub_i ? ~src2_i : src2_i;
         partial_q <= '0;
         c_q       <= sub_i;
         k_q       <= '0;
      end else if (state == S_BUSY) begin
         partial_q <= partial_nxt;
         c_q       <= step_sum[CHUNK];
         k_q       <= (k_q == K_LAST) ? '0 : k_q + KW'(1);
      end
   end

   // Result registers change only when DONE is entered, so partials never leak.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         sum_o  <= '0;
         cout_o <= 1'b0;
         ovf_o  <= 1'b0;
         zero_o <= 1'b0;
      end else if (last_step) begin
         sum_o  <= partial_nxt;
         cout_o <= step_sum[CHUNK];
         ovf_o  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (partial_nxt[WIDTH-1] != a_q[WIDTH-1]);
         zero_o <= (partial_nxt == '0);
      end
   end

endmodule

// File: doc/seq_adder_mc.md
Name: seq_adder_mc

Overview:
- Parametrised multi-cycle adder/subtractor, successor to the combinational 32-bit adder of the CPU datapath.
- Operands are captured on a start handshake. Each cycle the block adds CHUNK bits, with the carry rippled through a register between steps.
- It returns the sum with carry, signed-overflow and zero flags.
- It is used where a full-width combinational add would limit the clock, e.g. the multi-cycle ALU path.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CHUNK, 8, bits added per cycle. Must divide WIDTH; CHUNK==WIDTH is legal.
- STEPS, WIDTH/CHUNK, derived localparam. Not overridable.

Ports:
- clk_i  input  1  clock; all state changes on rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- start_i  input  1  request; accepted only when ready_o=1.
- sub_i  input  1  0 = src1+src2; 1 = src1-src2. Sampled with start_i.
- src1_i  input  WIDTH  operand A. Sampled with start_i.
- src2_i  input  WIDTH  operand B. Sampled with start_i.
- ready_o  output  1  block can accept start_i this cycle.
- valid_o  output  1  one-cycle pulse; result and flags are new this cycle.
- sum_o  output  WIDTH  result of the last completed operation.
- cout_o  output  1  carry out of the MSB. For subtract, 1 means no borrow.
- ovf_o  output  1  two's-complement signed overflow.
- zero_o  output  1  sum_o == 0.

Behaviour:
- Reset (rst_i=0, asynchronous, immediate):
  - state=IDLE, ready_o=1, valid_o=0.
  - sum_o, cout_o, ovf_o, zero_o all 0.
  - Internal operand, partial and step registers cleared.
  - A reset mid-operation aborts the operation with no valid_o pulse.
- States:
  - IDLE: ready_o=1.
  - BUSY: ready_o=0, step counter k = 0..STEPS-1.
  - DONE: ready_o=1, valid_o=1.
- Accept: start_i=1 and ready_o=1 at edge E.
  - Latch A=src1_i and B'=(sub_i ? ~src2_i : src2_i).
  - Carry register c=sub_i, k=0.
  - Go to BUSY.
- BUSY, each edge:
  - partial[k*CHUNK +: CHUNK] and c are updated from {c, partial slice} = A slice + B' slice + c.
  - k increments.
  - On the edge processing k=STEPS-1, go to DONE and load the outputs:
    - sum_o = full partial.
    - cout_o = final c.
    - ovf_o = (A[MSB]==B'[MSB]) && (sum[MSB]!=A[MSB]).
    - zero_o = (sum==0).
- Latency: start accepted at edge E, valid_o high in the cycle after edge E+STEPS, for exactly one cycle. With CHUNK=8, valid_o follows edge E+4; with STEPS=1, edge E+1.
- DONE to IDLE at the next edge, unless start_i=1 in DONE. That start is accepted and the block goes directly to BUSY, so back-to-back throughput is one operation per STEPS+1 cycles.
- start_i while BUSY: ignored. No queueing; operands and sub_i changes have no effect.
- Output hold: sum_o and the flags hold the last result through IDLE and through the BUSY phase of a later operation. They change only on the DONE-entry edge or on reset. Partial results are never visible on sum_o.
- Arithmetic: modulo 2^WIDTH with no saturation. Carry propagates across all chunk boundaries.

Test Plan:
1. Assert rst_i=0 for 2 cycles, then release -> ready_o=1, valid_o=0, sum_o=0, cout_o=ovf_o=zero_o=0.
2. start_i with sub_i=0, src1=0x7FFFFFFF, src2=0x00000001 (CHUNK=8) -> ready_o=0 for 4 cycles; valid_o pulses 1 cycle after edge E+4; sum_o=0x80000000, ovf_o=1, cout_o=0, zero_o=0.
3. Add 0xFFFFFFFF+0x00000001 -> carry ripples through all 4 chunks; sum_o=0, cout_o=1, zero_o=1, ovf_o=0.
4. Subtract 0x80000000-0x00000001 -> sum_o=0x7FFFFFFF, ovf_o=1, cout_o=1. Then subtract 5-5 -> sum_o=0, zero_o=1, cout_o=1, ovf_o=0.
5. Hold start_i high with new operands during BUSY -> ignored; first result unchanged. Assert start_i in the DONE cycle -> accepted, and the second valid_o follows STEPS+1 cycles after the first.
6. rst_i=0 asserted at step 2 of 3+4 -> all outputs 0 immediately, no valid_o; after release, a new 3+4 returns 7. Repeat with CHUNK=32 -> valid_o one cycle after start.
